// File: rtl/pci_pkg.sv
// Shared definitions for the PCI memory target: bus width, command codes,
// target FSM states and the byte-lane merge used by the register file.
package pci_pkg;

  localparam int BUS_W = 32;

  localparam logic [3:0] MEM_READ  = 4'b0110;
  localparam logic [3:0] MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BUSY = 3'd1,
    WAIT = 3'd2,
    DATA = 3'd3,
    TURN = 3'd4
  } state_t;

  // Replace each byte lane whose active-low enable is 0 with the new data.
  function automatic logic [BUS_W-1:0] byte_merge(input logic [BUS_W-1:0] old_word,
                                                  input logic [BUS_W-1:0] new_word,
                                                  input logic [3:0]       be_n);
    logic [BUS_W-1:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (!be_n[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/pci_target_mem.sv
// Word-addressed register file behind the PCI target: synchronous
// byte-enabled write, combinational read, cleared by the bus reset.
module pci_target_mem
  import pci_pkg::*;
#(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [3:0]           be_n,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [ADDR_BITS-1:0] raddr,
  input  logic [BUS_W-1:0]     wdata,
  output logic [BUS_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [BUS_W-1:0] mem_r [DEPTH];

  // Storage array: cleared on reset, byte-merged write on an enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (we) begin
      mem_r[waddr] <= byte_merge(mem_r[waddr], wdata, be_n);
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/pci_target.sv
// PCI memory target: claims MEM_READ / MEM_WRITE cycles inside its window,
// inserts the configured wait states, then serves single or burst
// transfers against the internal register file with in-window wrap.
module pci_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          ADDR_BITS = 4,
  parameter int          TRDY_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             irdy,
  input  logic [BUS_W-1:0] ad_in,
  input  logic [3:0]       cbe,
  output logic             devsel,
  output logic             trdy,
  output logic [BUS_W-1:0] ad_out,
  output logic             ad_oe
);

  // Reads always need at least one turnaround cycle before data.
  localparam int         RD_WAIT   = (TRDY_WAIT > 0) ? TRDY_WAIT : 1;
  localparam logic [7:0] WR_WAIT_C = 8'(TRDY_WAIT);
  localparam logic [7:0] RD_WAIT_C = 8'(RD_WAIT);

  state_t               state_r, state_s;
  logic [ADDR_BITS-1:0] index_r, index_s, index_inc_s, addr_idx_s, raddr_s;
  logic                 is_read_r, is_read_s;
  logic [7:0]           wait_cnt_r, wait_cnt_s, load_wait_s;
  logic [BUS_W-1:0]     rdata_s, ad_out_s;
  logic                 hit_s, cmd_ok_s, xfer_s, we_s;
  logic                 ad_lo_unused_s;

  // Byte offset within a word plays no part in decoding.
  assign ad_lo_unused_s = ^ad_in[1:0];

  assign hit_s       = (ad_in[BUS_W-1:ADDR_BITS+2] == BASE_ADDR[BUS_W-1:ADDR_BITS+2]);
  assign cmd_ok_s    = (cbe == MEM_READ) || (cbe == MEM_WRITE);
  assign addr_idx_s  = ad_in[ADDR_BITS+1:2];
  assign index_inc_s = index_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
  assign xfer_s      = (state_r == DATA) && !irdy && !trdy;
  assign we_s        = xfer_s && !is_read_r;

  pci_target_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .be_n  (cbe),
    .waddr (index_r),
    .raddr (raddr_s),
    .wdata (ad_in),
    .rdata (rdata_s)
  );

  // Next-state, index, wait counter and next read word selection.
  always_comb begin
    state_s     = state_r;
    index_s     = index_r;
    is_read_s   = is_read_r;
    wait_cnt_s  = wait_cnt_r;
    raddr_s     = index_r;
    ad_out_s    = ad_out;
    load_wait_s = (cbe == MEM_READ) ? RD_WAIT_C : WR_WAIT_C;
    case (state_r)
      IDLE: begin
        if (!frame) begin
          index_s    = addr_idx_s;
          is_read_s  = (cbe == MEM_READ);
          wait_cnt_s = load_wait_s;
          raddr_s    = addr_idx_s;
          if (hit_s && cmd_ok_s) begin
            if (load_wait_s != 8'd0) begin
              state_s = WAIT;
            end else begin
              state_s = DATA;
            end
            if (cbe == MEM_READ) begin
              ad_out_s = rdata_s;
            end else begin
              ad_out_s = ad_out;
            end
          end else begin
            state_s = BUSY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (frame && irdy) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      WAIT: begin
        if (is_read_r) begin
          ad_out_s = rdata_s;
        end else begin
          ad_out_s = ad_out;
        end
        if (wait_cnt_r <= 8'd1) begin
          wait_cnt_s = 8'd0;
          state_s    = DATA;
        end else begin
          wait_cnt_s = wait_cnt_r - 8'd1;
          state_s    = WAIT;
        end
      end
      DATA: begin
        // Prefetch the following word so read data is ready next phase.
        raddr_s = index_inc_s;
        if (xfer_s) begin
          index_s = index_inc_s;
          if (is_read_r) begin
            ad_out_s = rdata_s;
          end else begin
            ad_out_s = ad_out;
          end
          if (frame) begin
            state_s = TURN;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      TURN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers and registered bus outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      index_r    <= '0;
      is_read_r  <= 1'b0;
      wait_cnt_r <= 8'd0;
      devsel     <= 1'b1;
      trdy       <= 1'b1;
      ad_oe      <= 1'b0;
      ad_out     <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      index_r    <= index_s;
      is_read_r  <= is_read_s;
      wait_cnt_r <= wait_cnt_s;
      devsel     <= !((state_s == WAIT) || (state_s == DATA));
      trdy       <= !(state_s == DATA);
      ad_oe      <= is_read_s && ((state_s == WAIT) || (state_s == DATA));
      ad_out     <= ad_out_s;
    end
  end

endmodule

// File: tb/tb_pci_target.sv
// Self-checking bench for pci_target: a zero-wait instance and a
// TRDY_WAIT=2 instance share one initiator, selected by 'sel'.
`timescale 1ns/1ps
module tb_pci_target;
  import pci_pkg::*;

  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_b, irdy_b;
  logic [31:0] ad_b;
  logic [3:0]  cbe_b;
  int          sel;

  logic        frame0, frame1;
  logic        devsel0, trdy0, ad_oe0, devsel1, trdy1, ad_oe1;
  logic [31:0] ad_out0, ad_out1;
  logic        devsel_m, trdy_m, ad_oe_m;
  logic [31:0] ad_out_m;
  state_t      state_m;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [2][NW];
  logic [31:0] txn_data [NW];
  logic [3:0]  txn_be [NW];
  logic [31:0] rd_buf [NW];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  cmd;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          claim;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  assign frame0   = (sel == 0) ? frame_b : 1'b1;
  assign frame1   = (sel != 0) ? frame_b : 1'b1;
  assign devsel_m = (sel != 0) ? devsel1 : devsel0;
  assign trdy_m   = (sel != 0) ? trdy1   : trdy0;
  assign ad_oe_m  = (sel != 0) ? ad_oe1  : ad_oe0;
  assign ad_out_m = (sel != 0) ? ad_out1 : ad_out0;
  assign state_m  = (sel != 0) ? dut_w.state_r : dut.state_r;

  pci_target #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(4), .TRDY_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame0), .irdy(irdy_b), .ad_in(ad_b), .cbe(cbe_b),
    .devsel(devsel0), .trdy(trdy0), .ad_out(ad_out0), .ad_oe(ad_oe0));

  pci_target #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(4), .TRDY_WAIT(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .frame(frame1), .irdy(irdy_b), .ad_in(ad_b), .cbe(cbe_b),
    .devsel(devsel1), .trdy(trdy1), .ad_out(ad_out1), .ad_oe(ad_oe1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_ref();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < NW; w++) ref_mem[d][w] = 32'h0;
  endtask

  // One claimed transaction of n data phases on the selected target.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                         input int stall_phase, input int stall_len, input int abort_after);
    int i, cyc, stall_left, first_trdy, idx0, wexp, tw, w;
    bit wr, aborted;
    wr = (cmd == MEM_WRITE);
    tw = (sel == 0) ? 0 : 2;
    wexp = wr ? tw : ((tw > 1) ? tw : 1);
    idx0 = int'(addr[5:2]);
    i = 0; cyc = 0; stall_left = stall_len; first_trdy = -1; aborted = 1'b0;
    @(negedge clk);
    frame_b = 1'b0; irdy_b = 1'b1; ad_b = addr; cbe_b = cmd;
    @(negedge clk);
    cyc = 1;
    chk("devsel_claim", devsel_m, 32'd0);
    while (i < n && cyc < 200 && !aborted) begin
      if (first_trdy < 0 && trdy_m == 1'b0) first_trdy = cyc;
      frame_b = (i == n - 1);
      if (i == stall_phase && stall_left > 0) begin
        irdy_b = 1'b1;
        stall_left--;
      end else begin
        irdy_b = 1'b0;
      end
      ad_b  = wr ? txn_data[i] : $urandom;
      cbe_b = wr ? txn_be[i] : 4'h0;
      if (!irdy_b && !trdy_m) begin
        w = (idx0 + i) % NW;
        if (wr) begin
          for (int k = 0; k < 4; k++)
            if (!txn_be[i][k]) ref_mem[sel][w][8*k +: 8] = txn_data[i][8*k +: 8];
        end else begin
          chk("rd_data", ad_out_m, ref_mem[sel][w]);
          chk("rd_oe", ad_oe_m, 32'd1);
          rd_buf[i] = ad_out_m;
        end
        i++;
      end
      @(negedge clk);
      cyc++;
      if (abort_after >= 0 && i == abort_after) aborted = 1'b1;
    end
    if (!aborted) begin
      chk("txn_done", i, n);
      chk("trdy_latency", first_trdy, 1 + wexp);
      frame_b = 1'b1; irdy_b = 1'b1;
      chk("turn_devsel", devsel_m, 32'd1);
      chk("turn_trdy", trdy_m, 32'd1);
      chk("turn_oe", ad_oe_m, 32'd0);
      chk("turn_state", state_m, TURN);
      @(negedge clk);
      chk("idle_state", state_m, IDLE);
    end
  endtask

  // Transaction the selected target must ignore.
  task automatic run_miss(input logic [31:0] addr, input logic [3:0] cmd);
    @(negedge clk);
    frame_b = 1'b0; irdy_b = 1'b1; ad_b = addr; cbe_b = cmd;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("miss_devsel", devsel_m, 32'd1);
      chk("miss_trdy", trdy_m, 32'd1);
      chk("miss_busy", state_m, BUSY);
      frame_b = (c >= 1);
      irdy_b  = (c == 2);
      ad_b    = $urandom;
    end
    @(negedge clk);
    chk("miss_idle", state_m, IDLE);
    chk("miss_devsel_end", devsel_m, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sel = 0; rst_n = 1'b0; frame_b = 1'b1; irdy_b = 1'b1; ad_b = 32'h0; cbe_b = 4'h0;
    clear_ref();
    for (int i = 0; i < NW; i++) begin txn_data[i] = 32'h0; txn_be[i] = 4'h0; rd_buf[i] = 32'h0; end

    tbl[0]  = '{32'h0000_1008, MEM_WRITE, 32'hDEAD_BEEF, 4'h0,    1'b1, 32'h0};
    tbl[1]  = '{32'h0000_1008, MEM_READ,  32'h0,         4'h0,    1'b1, 32'hDEAD_BEEF};
    tbl[2]  = '{32'h0000_1004, MEM_WRITE, 32'h1122_3344, 4'b1110, 1'b1, 32'h0};
    tbl[3]  = '{32'h0000_1004, MEM_READ,  32'h0,         4'h0,    1'b1, 32'h0000_0044};
    tbl[4]  = '{32'h0000_1007, MEM_WRITE, 32'hAABB_CCDD, 4'b0001, 1'b1, 32'h0};
    tbl[5]  = '{32'h0000_1005, MEM_READ,  32'h0,         4'h0,    1'b1, 32'hAABB_CC44};
    tbl[6]  = '{32'h0000_1000, MEM_WRITE, 32'hFFFF_FFFF, 4'hF,    1'b1, 32'h0};
    tbl[7]  = '{32'h0000_1000, MEM_READ,  32'h0,         4'h0,    1'b1, 32'h0};
    tbl[8]  = '{32'h0000_2000, MEM_WRITE, 32'h0,         4'h0,    1'b0, 32'h0};
    tbl[9]  = '{32'h0000_1000, 4'b0010,   32'h0,         4'h0,    1'b0, 32'h0};
    tbl[10] = '{32'h0000_1040, MEM_READ,  32'h0,         4'h0,    1'b0, 32'h0};
    tbl[11] = '{32'h0000_103C, MEM_READ,  32'h0,         4'h0,    1'b1, 32'h0};

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    chk("rst_devsel", devsel0, 32'd1);
    chk("rst_trdy", trdy0, 32'd1);
    chk("rst_oe", ad_oe0, 32'd0);
    chk("rst_ad_out", ad_out0, 32'h0);
    chk("rst_state", dut.state_r, IDLE);
    chk("rst_w_devsel", devsel1, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-phase table.
    for (int t = 0; t < 12; t++) begin
      if (tbl[t].claim) begin
        txn_data[0] = tbl[t].wdata;
        txn_be[0]   = tbl[t].be;
        run_txn(tbl[t].addr, tbl[t].cmd, 1, -1, 0, -1);
        if (tbl[t].cmd == MEM_READ) chk($sformatf("tbl%0d_rd", t), rd_buf[0], tbl[t].exp);
      end else begin
        run_miss(tbl[t].addr, tbl[t].cmd);
      end
    end

    // Four-word burst write with a half-word phase, then read it back.
    txn_data[0] = 32'h1111_1111; txn_be[0] = 4'h0;
    txn_data[1] = 32'h2222_2222; txn_be[1] = 4'h0;
    txn_data[2] = 32'h1234_5678; txn_be[2] = 4'b1100;
    txn_data[3] = 32'h4444_4444; txn_be[3] = 4'h0;
    run_txn(32'h0000_1000, MEM_WRITE, 4, -1, 0, -1);
    run_txn(32'h0000_1000, MEM_READ, 4, -1, 0, -1);
    chk("burst_w0", rd_buf[0], 32'h1111_1111);
    chk("burst_w2_half", rd_buf[2], 32'hDEAD_5678);
    chk("burst_w3", rd_buf[3], 32'h4444_4444);

    // Wrap-around from the last word of the window.
    txn_data[0] = 32'hA5A5_0001; txn_data[1] = 32'hA5A5_0002; txn_data[2] = 32'hA5A5_0003;
    for (int i = 0; i < 3; i++) txn_be[i] = 4'h0;
    run_txn(32'h0000_103C, MEM_WRITE, 3, -1, 0, -1);
    run_txn(32'h0000_103C, MEM_READ, 4, -1, 0, -1);
    chk("wrap_15", rd_buf[0], 32'hA5A5_0001);
    chk("wrap_0", rd_buf[1], 32'hA5A5_0002);
    chk("wrap_1", rd_buf[2], 32'hA5A5_0003);
    chk("wrap_2_kept", rd_buf[3], 32'hDEAD_5678);

    // Randomized bursts against the reference model.
    for (int r = 0; r < 25; r++) begin
      int n;
      logic [31:0] a;
      n = $urandom_range(1, 6);
      a = 32'h0000_1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin txn_data[i] = $urandom; txn_be[i] = 4'($urandom_range(0, 15)); end
      run_txn(a, ($urandom_range(0, 1) != 0) ? MEM_WRITE : MEM_READ, n,
              $urandom_range(0, 5), $urandom_range(0, 2), -1);
    end
    run_txn(32'h0000_1000, MEM_READ, 16, -1, 0, -1);

    // TRDY_WAIT=2 instance: wait latency and an initiator stall mid-burst.
    sel = 1;
    for (int i = 0; i < 4; i++) begin txn_data[i] = $urandom; txn_be[i] = 4'h0; end
    run_txn(32'h0000_1010, MEM_WRITE, 4, 2, 2, -1);
    run_txn(32'h0000_1000, MEM_READ, 16, 5, 2, -1);
    chk("wait_no_extra", rd_buf[8], 32'h0);
    chk("wait_word6", rd_buf[6], txn_data[2]);

    // Reset in the middle of a burst after two transfers.
    sel = 0;
    for (int i = 0; i < 4; i++) begin txn_data[i] = $urandom | 32'h1; txn_be[i] = 4'h0; end
    run_txn(32'h0000_1020, MEM_WRITE, 4, -1, 0, 2);
    chk("pre_rst_devsel", devsel0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_devsel", devsel0, 32'd1);
    chk("async_trdy", trdy0, 32'd1);
    chk("async_oe", ad_oe0, 32'd0);
    chk("async_mem", dut.u_mem.mem_r[8], 32'h0);
    frame_b = 1'b1; irdy_b = 1'b1;
    clear_ref();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", state_m, IDLE);
    run_txn(32'h0000_1000, MEM_READ, 16, -1, 0, -1);
    sel = 1;
    run_txn(32'h0000_1000, MEM_READ, 4, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pci_target.md
Name: pci_target

Overview:
- Simple PCI memory target on the shared bus, sitting downstream of the bus-phase state machine.
- Responds to the signals the initiator produces: frame, irdy, address/command.
- Claims transactions in its address window by driving devsel and trdy.
- Serves single and burst memory reads/writes from a small internal byte-enabled register file.

Parameters:
- BASE_ADDR, 32'h0000_1000: base of claimed window; must be aligned to the window size.
- ADDR_BITS, 4: word-index width; window is 2^ADDR_BITS 32-bit words (64 bytes at default).
- TRDY_WAIT, 0: extra target wait cycles inserted before the first data phase of every claimed transaction.

Ports:
- clk  in  1  bus clock; all sampling on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame  in  1  active-low; initiator transaction framing.
- irdy  in  1  active-low; initiator ready.
- ad_in  in  32  address during address phase, write data during data phases.
- cbe  in  4  command during address phase; active-low byte enables during data phases.
- devsel  out  1  active-low device select, registered.
- trdy  out  1  active-low target ready, registered.
- ad_out  out  32  read data, registered.
- ad_oe  out  1  high when this target drives ad, registered.

Behaviour:
- Reset (async, rst_n=0):
  - devsel=1, trdy=1, ad_oe=0, ad_out=0.
  - state=IDLE, memory cleared to 0.
  - Reset mid-transaction abandons it with no partial side effects beyond words already written.
- Commands (from shared package):
  - MEM_READ=4'b0110, MEM_WRITE=4'b0111.
  - Any other command is not claimed.
- Hit condition: ad_in[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2].
  - ad_in[1:0] is ignored.
  - Word index = ad_in[ADDR_BITS+1:2].
- FSM states: IDLE, BUSY, WAIT, DATA, TURN.
- IDLE:
  - On an edge with frame=0, latch index and cmd.
  - Hit with supported cmd -> WAIT if wait count > 0, else DATA.
  - Otherwise -> BUSY.
- Wait count:
  - Writes: TRDY_WAIT.
  - Reads: max(TRDY_WAIT, 1), giving one mandatory turnaround cycle.
- BUSY: transaction not ours; outputs stay deasserted. Return to IDLE on an edge with frame=1 and irdy=1.
- WAIT:
  - devsel=0, trdy=1.
  - Reads: ad_oe=1, ad_out=mem[index].
  - Counter decrements each cycle; -> DATA when it reaches 0.
- DATA:
  - devsel=0, trdy=0.
  - Transfer occurs on an edge where irdy=0 and trdy=0.
  - Write transfer: mem[index] byte k <= ad_in byte k for each cbe[k]=0; cbe=4'hF writes nothing.
  - Read transfer: ad_out updates to mem[index+1] for the next phase, so it is valid in the cycle after the transfer.
  - After each transfer, index += 1 modulo 2^ADDR_BITS (wrap-around inside window; no disconnect).
  - irdy=1 (initiator wait): no transfer; index, data and outputs held.
  - Transfer with frame=1 (final data phase) -> TURN.
- TURN: devsel=1, trdy=1, ad_oe=0 -> IDLE.
- Latency: devsel asserts in the first cycle after the address edge. First trdy=0 appears 1+waitcount cycles after the address edge.
- Read-after-write within the same burst at the wrapped index returns the updated value.
- frame=1 while irdy=1 in DATA is a protocol violation: hold state, no transfer.

Decomposition:
- Shared package pci_pkg holds:
  - Command codes (MEM_READ, MEM_WRITE).
  - FSM state enum (IDLE, BUSY, WAIT, DATA, TURN).
  - Bus-width constant 32.
- Natural sub-module: pci_target_mem, a 2^ADDR_BITS x 32 register file with 4 active-low byte write enables, synchronous write, combinational read, and async clear on rst_n.

Test Plan:
- Single write then single read: write 0xDEADBEEF to 0x1008 (cbe=0), final phase; then read 0x1008 -> write devsel=0 the cycle after the address edge, read trdy=0 two cycles after the address edge, ad_out=0xDEADBEEF, TURN then IDLE.
- Burst write of 4 words at 0x1000 with cbe=0,0,4'b1100,0 -> mem[0..3] hold the data, mem[2] with only its low 16 bits updated; read-back burst returns identical values.
- Address miss at 0x2000 and unsupported cmd 4'b0010 at 0x1000 -> devsel/trdy stay 1 for the entire transaction; FSM in BUSY until frame=1 and irdy=1.
- TRDY_WAIT=2 write -> trdy=0 exactly 3 cycles after the address edge; initiator holds irdy=1 for 2 cycles mid-burst -> no extra writes, index unchanged.
- Wrap-around: burst write of 3 words starting at 0x103C (index 15) -> writes index 15, 0, 1.
- rst_n pulled low mid-burst after 2 transfers -> devsel/trdy go 1 and ad_oe goes 0 immediately without a clock; after release, FSM is in IDLE and memory reads back 0.
